precog_gap_predictor: RTL and testbench

Transmit-arbitration helper for the packet badger. It watches the receive scanner's busy flag, which runs LATENCY cycles ahead of the shared output stream. It detects idle gaps long enough to carry a pending transmit packet and grants `clear_to_send` exactly LATENCY cycles later, aligned with that gap on the output side. The grant window is exactly `tx_packet_width` cycles, so the transmitter never collides with forwarded receive traffic.

---
 rtl/precog_gap_predictor.sv | 130 +++++++++++++
 tb/tb_precog_gap_predictor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/precog_gap_predictor.sv
// precog_gap_predictor: finds idle gaps on the receive scanner, which runs
// LATENCY cycles ahead of the output stream, and grants clear_to_send so that
// the grant lands exactly on that gap when it reaches the output side.
// Optional build macro: PRECOG_STATS_EN adds a 16-bit grant_count output.
module precog_gap_predictor #(
    parameter int PAW     = 11,
    parameter int LATENCY = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [PAW-1:0] tx_packet_width,
    input  logic           scanner_busy,
    input  logic           request_to_send,
`ifdef PRECOG_STATS_EN
    output logic [15:0]    grant_count,
`endif
    output logic           clear_to_send
);

    // Delay line of granted idle samples; index 0 is the sample taken at the
    // most recent edge, index DL-1 feeds the output register.
    localparam int DL = LATENCY - 1;

    typedef enum logic {
        S_WAIT,
        S_COUNT
    } state_t;

    state_t         state_q;
    logic [PAW-1:0] cnt_q;
    logic [PAW-1:0] w_q;
    logic           pending_q;
    logic           prev_busy_q;
    logic           after_q;
    logic [DL-1:0]  line_q;
    logic [DL-1:0]  line_d;
    logic           clear_to_send_q;

    logic           fresh;
    logic           start;
    logic           commit;
    logic [PAW-1:0] commit_w;

    // Window start / commit decisions for the sample taken at this edge.
    always_comb begin
        fresh    = prev_busy_q | after_q;
        start    = (state_q == S_WAIT) && !scanner_busy && fresh
                   && (pending_q || request_to_send)
                   && (tx_packet_width != '0);
        commit   = 1'b0;
        commit_w = w_q;
        if (state_q == S_COUNT) begin
            // The idle sample at this edge brings the count up to W.
            if (!scanner_busy && ((cnt_q + PAW'(1)) == w_q)) begin
                commit = 1'b1;
            end
        end else if (start && (tx_packet_width == PAW'(1))) begin
            // A one-cycle packet is committed on its very first idle sample.
            commit   = 1'b1;
            commit_w = tx_packet_width;
        end
    end

    // On commit, retroactively mark the last W samples (the whole window)
    // as granted; everything else just shifts toward the output.
    for (genvar gi = 0; gi < DL; gi++) begin : g_line
        logic shifted;
        if (gi == 0) begin : g_head
            assign shifted = 1'b0;
        end else begin : g_body
            assign shifted = line_q[gi-1];
        end
        assign line_d[gi] = shifted | (commit && (PAW'(gi) < commit_w));
    end

    // Window tracker, pending latch, delay line and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_WAIT;
            cnt_q           <= '0;
            w_q             <= '0;
            pending_q       <= 1'b0;
            prev_busy_q     <= 1'b0;
            after_q         <= 1'b0;
            line_q          <= '0;
            clear_to_send_q <= 1'b0;
        end else begin
            line_q          <= line_d;
            clear_to_send_q <= line_q[DL-1];
            prev_busy_q     <= scanner_busy;
            after_q         <= commit;
            pending_q       <= commit ? 1'b0 : (pending_q | request_to_send);
            case (state_q)
                S_COUNT: begin
                    // Busy aborts the window; commit closes it.
                    if (scanner_busy || commit) begin
                        state_q <= S_WAIT;
                    end else begin
                        cnt_q <= cnt_q + PAW'(1);
                    end
                end
                default: begin
                    if (start && !commit) begin
                        state_q <= S_COUNT;
                        cnt_q   <= PAW'(1);
                        w_q     <= tx_packet_width;
                    end
                end
            endcase
        end
    end

    assign clear_to_send = clear_to_send_q;

`ifdef PRECOG_STATS_EN
    logic [15:0] grant_count_q;

    // Count committed grants; wraps naturally at 0xFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count_q <= '0;
        end else if (commit) begin
            grant_count_q <= grant_count_q + 16'd1;
        end
    end

    assign grant_count = grant_count_q;
`endif

endmodule

// File: tb/tb_precog_gap_predictor.sv
// Testbench for precog_gap_predictor: directed gap scenarios, held request,
// reset during a committed grant, then randomized traffic. A reference model
// marks granted scanner samples; expected output is that record delayed.
module tb_precog_gap_predictor;

    localparam int PAW     = 11;
    localparam int LATENCY = 10;
    localparam int NCYC    = 8000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [PAW-1:0] tx_packet_width = '0;
    logic           scanner_busy = 1'b1;
    logic           request_to_send = 1'b0;
    logic           clear_to_send;
`ifdef PRECOG_STATS_EN
    logic [15:0]    grant_count;
`endif

    precog_gap_predictor #(.PAW(PAW), .LATENCY(LATENCY)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tx_packet_width (tx_packet_width),
        .scanner_busy    (scanner_busy),
        .request_to_send (request_to_send),
`ifdef PRECOG_STATS_EN
        .grant_count     (grant_count),
`endif
        .clear_to_send   (clear_to_send)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        bit exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;
    bit   done = 1'b0;

    // Reference model state: granted[i] = scanner sample i lies in a grant.
    bit   granted[NCYC];
    int   t = 0;
    bit   m_pending = 0;
    bit   m_prev_busy = 0;
    bit   m_after = 0;
    bit   m_inwin = 0;
    int   m_ws = 0;
    int   m_w = 0;
    int   m_grants = 0;

    task automatic model_commit();
        for (int i = m_ws; i <= t; i++) granted[i] = 1'b1;
        m_pending = 0;
        m_inwin   = 0;
        m_after   = 1;
        m_grants++;
    endtask

    // Apply the gap rules to the sample at edge t and queue the expected
    // output register value just after that edge.
    task automatic model_step(input bit rst, input bit b, input bit r, input int w);
        exp_t e;
        bit   fresh;
        if (rst) begin
            m_pending = 0; m_prev_busy = 0; m_after = 0; m_inwin = 0; m_grants = 0;
            for (int i = 0; i <= t; i++) granted[i] = 1'b0;
            e.exp = 1'b0;
        end else begin
            fresh   = m_prev_busy || m_after;
            m_after = 0;
            if (r) m_pending = 1;
            if (m_inwin) begin
                if (b) m_inwin = 0;
                else if (t - m_ws + 1 == m_w) model_commit();
            end else if (!b && fresh && m_pending && w != 0) begin
                m_ws = t; m_w = w; m_inwin = 1;
                if (w == 1) model_commit();
            end
            m_prev_busy = b;
            e.exp = (t - LATENCY + 1 >= 0) ? granted[t - LATENCY + 1] : 1'b0;
        end
        e.t = t;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit rst, input bit b, input bit r, input int w);
        @(negedge clk);
        rst_n           = !rst;
        scanner_busy    = b;
        request_to_send = r;
        tx_packet_width = PAW'(w);
        model_step(rst, b, r, w);
        started = 1'b1;
        t++;
        if (t >= NCYC) begin
            $display("FAIL cycle_budget: reached %0d cycles, limit %0d", t, NCYC);
            $fatal(1, "cycle budget exceeded");
        end
    endtask

    task automatic scenario(input int w, input int g);
        for (int i = 0; i < 11; i++) cyc(0, 1, 0, w);
        cyc(0, 1, 1, w);
        for (int i = 0; i < g; i++) cyc(0, 0, 0, w);
        for (int i = 0; i < 26; i++) cyc(0, 1, 0, w);
    endtask

    // Monitor: one comparison per clock edge against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!done && started) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL queue_underflow: no expectation at time %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (clear_to_send !== e.exp) begin
                        errors++;
                        $display("FAIL cts edge %0d: got %b expected %b", e.t, clear_to_send, e.exp);
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int busy_left;
        int idle_left;
        int w;
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 5);

        for (int g = 1; g <= 6; g++) scenario(5, g);
        scenario(7, 6);
        scenario(7, 7);
        scenario(8, 8);
        scenario(8, 9);
        scenario(1, 1);
        scenario(0, 10);

        // Request held high across a long idle stretch.
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 4);
        for (int i = 0; i < 100; i++) cyc(0, 0, 1, 4);
        for (int i = 0; i < 30; i++) cyc(0, 1, 0, 4);

        // Reset while a committed grant is still in the delay line.
        for (int i = 0; i < 11; i++) cyc(0, 1, 0, 5);
        cyc(0, 1, 1, 5);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 5);
        cyc(1, 0, 0, 5);
        cyc(1, 0, 0, 5);
        for (int i = 0; i < 14; i++) cyc(0, 1, 0, 5);
        scenario(5, 5);

        // Randomized traffic.
        busy_left = 3;
        idle_left = 0;
        w = 5;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) w = $urandom_range(0, 8);
            if ($urandom_range(0, 799) == 0) begin
                cyc(1, 1, 0, w);
                cyc(1, 0, 0, w);
            end
            if (busy_left == 0 && idle_left == 0) begin
                busy_left = $urandom_range(1, 6);
                idle_left = $urandom_range(1, 12);
            end
            if (busy_left > 0) begin
                cyc(0, 1, ($urandom_range(0, 7) == 0), w);
                busy_left--;
            end else begin
                cyc(0, 0, ($urandom_range(0, 15) == 0), w);
                idle_left--;
            end
        end
        for (int i = 0; i < LATENCY + 10; i++) cyc(0, 1, 0, 5);

        @(posedge clk);
        #2;
        done = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d leftover expectations, expected 0", exp_q.size());
        end
`ifdef PRECOG_STATS_EN
        checks++;
        if (grant_count !== 16'(m_grants)) begin
            errors++;
            $display("FAIL grant_count: got %0d expected %0d", grant_count, m_grants);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
